// File: rtl/traffic_lights_pkg.sv
// Shared types and constants for the multi-direction intersection controller.
package traffic_lights_pkg;

   localparam int MS_W         = 16;
   localparam int NUM_DIRS_DEF = 4;
   localparam int DIR_W        = $clog2(NUM_DIRS_DEF);

   typedef enum logic [2:0] {
      CMD_ON         = 3'd0,
      CMD_OFF        = 3'd1,
      CMD_UNREG      = 3'd2,
      CMD_SET_GREEN  = 3'd3,
      CMD_SET_CLEAR  = 3'd4,
      CMD_SET_YELLOW = 3'd5
   } cmd_type_e;

   typedef enum logic [2:0] {
      ST_OFF,
      ST_UNREG,
      ST_CLEAR,
      ST_RY,
      ST_GREEN,
      ST_GBLINK,
      ST_YELLOW
   } state_t;

   // A programmed time of zero would never expire cleanly, so clamp it to 1 ms.
   function automatic logic [MS_W-1:0] min1_ms(input logic [MS_W-1:0] ms);
      return (ms == '0) ? MS_W'(1) : ms;
   endfunction

endpackage

// File: rtl/tl_ms_timer.sv
// Millisecond timer: a CLKS_PER_MS prescaler driving a loadable 16-bit ms
// down-counter. done_o pulses in the last clock cycle of the loaded interval,
// so a load of T ms followed by a reload on done_o spans exactly
// T*CLKS_PER_MS cycles.
module tl_ms_timer
   import traffic_lights_pkg::*;
#(
   parameter int CLKS_PER_MS = 2
) (
   input  logic            clk_i,
   input  logic            srst_i,
   input  logic            load_i,
   input  logic [MS_W-1:0] load_ms_i,
   output logic            done_o
);

   localparam int PW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;

   logic [PW-1:0]   pre_q;
   logic [MS_W-1:0] ms_q;
   logic            tick;

   assign tick   = (pre_q == PW'(CLKS_PER_MS - 1));
   assign done_o = tick && (ms_q == MS_W'(1));

   // Prescaler restarts on load; the ms counter saturates at zero.
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         pre_q <= '0;
         ms_q  <= '0;
      end else if (load_i) begin
         pre_q <= '0;
         ms_q  <= load_ms_i;
      end else begin
         pre_q <= tick ? '0 : pre_q + PW'(1);
         if (tick && (ms_q != '0)) begin
            ms_q <= ms_q - MS_W'(1);
         end
      end
   end

endmodule

// File: rtl/traffic_lights_xing.sv
// N-direction intersection controller. Serves one direction at a time in
// round-robin order with an all-red clearance between directions.
// Optional feature macro: TL_DEMAND_SKIP_EN adds demand_i and skips
// directions without demand when leaving the clearance phase.
//
// Command handshake: a command is a single-cycle strobe; it is acted on in
// the cycle where cmd_valid_i is high and its effect is visible on the
// registered lamp outputs one cycle later. There is no back-pressure:
// commands that are not legal in the current state are silently dropped.
module traffic_lights_xing
   import traffic_lights_pkg::*;
#(
   parameter int NUM_DIRS              = 4,
   parameter int CLKS_PER_MS           = 2,
   parameter int BLINK_HALF_PERIOD_MS  = 1,
   parameter int BLINK_GREEN_TIME_TICK = 3,
   parameter int RED_YELLOW_MS         = 1,
   parameter int DEF_GREEN_MS          = 10,
   parameter int DEF_YELLOW_MS         = 2,
   parameter int DEF_CLEAR_MS          = 2
) (
   input  logic                        clk_i,
   input  logic                        srst_i,
   input  logic [2:0]                  cmd_type_i,
   input  logic                        cmd_valid_i,
   input  logic [$clog2(NUM_DIRS)-1:0] cmd_dir_i,
   input  logic [MS_W-1:0]             cmd_data_i,
`ifdef TL_DEMAND_SKIP_EN
   input  logic [NUM_DIRS-1:0]         demand_i,
`endif
   output logic [NUM_DIRS-1:0]         red_o,
   output logic [NUM_DIRS-1:0]         yellow_o,
   output logic [NUM_DIRS-1:0]         green_o,
   output logic [$clog2(NUM_DIRS)-1:0] active_dir_o,
   output state_t                      state_o
);

   localparam int DW = $clog2(NUM_DIRS);
   localparam logic [MS_W-1:0] GBLINK_MS = MS_W'(2 * BLINK_HALF_PERIOD_MS * BLINK_GREEN_TIME_TICK);

   state_t          state_q, state_d;
   logic [DW-1:0]   dir_q, dir_d;
   logic            phase_q, phase_d;
   logic            restart;
   logic            main_load;
   logic [MS_W-1:0] main_ms;
   logic            main_done;
   logic            blink_done;
   logic            is_idle;
   logic            dir_ok;
   cmd_type_e       cmd;

   logic [MS_W-1:0] green_ms_q [NUM_DIRS];
   logic [MS_W-1:0] yellow_ms_q;
   logic [MS_W-1:0] clear_ms_q;

   logic [NUM_DIRS-1:0] red_q, yel_q, grn_q;
   logic [NUM_DIRS-1:0] red_d, yel_d, grn_d;
   logic [NUM_DIRS-1:0] dir_mask;

`ifdef TL_DEMAND_SKIP_EN
   logic          found;
   logic [DW-1:0] pick;
   logic [DW-1:0] idx_dw;
   int            idx;
`endif

   assign cmd     = cmd_type_e'(cmd_type_i);
   assign is_idle = (state_q == ST_OFF) || (state_q == ST_UNREG);
   assign dir_ok  = (int'(cmd_dir_i) < NUM_DIRS);

   tl_ms_timer #(.CLKS_PER_MS(CLKS_PER_MS)) u_main_timer (
      .clk_i     (clk_i),
      .srst_i    (srst_i),
      .load_i    (main_load),
      .load_ms_i (main_ms),
      .done_o    (main_done)
   );

   // Blink half-period timer free-runs, restarting on every state entry.
   tl_ms_timer #(.CLKS_PER_MS(CLKS_PER_MS)) u_blink_timer (
      .clk_i     (clk_i),
      .srst_i    (srst_i),
      .load_i    (restart || blink_done),
      .load_ms_i (MS_W'(BLINK_HALF_PERIOD_MS)),
      .done_o    (blink_done)
   );

   // Next-state, next direction and timer reload decisions.
   always_comb begin
      state_d   = state_q;
      dir_d     = dir_q;
      restart   = 1'b0;
      main_load = 1'b0;
      main_ms   = MS_W'(1);
`ifdef TL_DEMAND_SKIP_EN
      // Search starts at the direction after the current one; current is last.
      found  = 1'b0;
      pick   = dir_q;
      idx    = 0;
      idx_dw = '0;
      for (int k = 1; k <= NUM_DIRS; k++) begin
         idx = int'(dir_q) + k;
         if (idx >= NUM_DIRS) idx = idx - NUM_DIRS;
         idx_dw = DW'(idx);
         if (!found && demand_i[idx_dw]) begin
            found = 1'b1;
            pick  = idx_dw;
         end
      end
`endif
      case (state_q)
         ST_CLEAR: if (main_done) begin
`ifdef TL_DEMAND_SKIP_EN
            if (found) begin
               state_d = ST_RY;
               dir_d   = pick;
               restart = 1'b1;
            end else begin
               // No demand: hold all-red and re-check on every ms boundary.
               main_load = 1'b1;
            end
`else
            state_d = ST_RY;
            restart = 1'b1;
`endif
         end
         ST_RY:     if (main_done) begin state_d = ST_GREEN;  restart = 1'b1; end
         ST_GREEN:  if (main_done) begin state_d = ST_GBLINK; restart = 1'b1; end
         ST_GBLINK: if (main_done) begin state_d = ST_YELLOW; restart = 1'b1; end
         ST_YELLOW: if (main_done) begin
            state_d = ST_CLEAR;
            restart = 1'b1;
`ifndef TL_DEMAND_SKIP_EN
            dir_d = (dir_q == DW'(NUM_DIRS - 1)) ? '0 : dir_q + DW'(1);
`endif
         end
         default: ;
      endcase

      if (cmd_valid_i) begin
         case (cmd)
            CMD_OFF:   begin state_d = ST_OFF;   restart = 1'b1; end
            CMD_UNREG: begin state_d = ST_UNREG; restart = 1'b1; end
            CMD_ON: if (is_idle) begin
               state_d = ST_CLEAR;
               dir_d   = '0;
               restart = 1'b1;
            end
            default: ;
         endcase
      end

      if (restart) begin
         main_load = 1'b1;
         case (state_d)
            ST_CLEAR:  main_ms = clear_ms_q;
            ST_RY:     main_ms = MS_W'(RED_YELLOW_MS);
            ST_GREEN:  main_ms = green_ms_q[dir_d];
            ST_GBLINK: main_ms = GBLINK_MS;
            ST_YELLOW: main_ms = yellow_ms_q;
            default:   main_ms = MS_W'(1);
         endcase
      end
   end

   // Blink phase and lamp pattern for the state being entered.
   always_comb begin
      if (restart)         phase_d = (state_d == ST_UNREG);
      else if (blink_done) phase_d = ~phase_q;
      else                 phase_d = phase_q;

      dir_mask = NUM_DIRS'(1) << dir_d;
      red_d    = '0;
      yel_d    = '0;
      grn_d    = '0;
      case (state_d)
         ST_UNREG:  yel_d = {NUM_DIRS{phase_d}};
         ST_CLEAR:  red_d = '1;
         ST_RY:     begin red_d = '1;        yel_d = dir_mask; end
         ST_GREEN:  begin red_d = ~dir_mask; grn_d = dir_mask; end
         ST_GBLINK: begin red_d = ~dir_mask; grn_d = phase_d ? dir_mask : '0; end
         ST_YELLOW: begin red_d = ~dir_mask; yel_d = dir_mask; end
         default: ;
      endcase
   end

   // State, direction, blink phase and registered lamp outputs.
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         state_q <= ST_OFF;
         dir_q   <= '0;
         phase_q <= 1'b0;
         red_q   <= '0;
         yel_q   <= '0;
         grn_q   <= '0;
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         phase_q <= phase_d;
         red_q   <= red_d;
         yel_q   <= yel_d;
         grn_q   <= grn_d;
      end
   end

   // Programmable times; writable only while unregulated.
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         for (int i = 0; i < NUM_DIRS; i++) green_ms_q[i] <= MS_W'(DEF_GREEN_MS);
         yellow_ms_q <= MS_W'(DEF_YELLOW_MS);
         clear_ms_q  <= MS_W'(DEF_CLEAR_MS);
      end else if (cmd_valid_i && (state_q == ST_UNREG)) begin
         case (cmd)
            CMD_SET_GREEN:  if (dir_ok) green_ms_q[cmd_dir_i] <= min1_ms(cmd_data_i);
            CMD_SET_CLEAR:  clear_ms_q  <= min1_ms(cmd_data_i);
            CMD_SET_YELLOW: yellow_ms_q <= min1_ms(cmd_data_i);
            default: ;
         endcase
      end
   end

   assign red_o        = red_q;
   assign yellow_o     = yel_q;
   assign green_o      = grn_q;
   assign active_dir_o = dir_q;
   assign state_o      = state_q;

endmodule

// File: tb/tb_traffic_lights_xing.sv
// Bench for traffic_lights_xing with NUM_DIRS=3, CLKS_PER_MS=2.
// Build with TL_DEMAND_SKIP_EN defined to add the demand-skip sequences.
module tb_traffic_lights_xing;
   import traffic_lights_pkg::*;

   localparam int CLK_HALF = 5;

   logic        clk;
   logic        srst;
   logic [2:0]  cmd_type;
   logic        cmd_valid;
   logic [1:0]  cmd_dir;
   logic [15:0] cmd_data;
`ifdef TL_DEMAND_SKIP_EN
   logic [2:0]  demand;
`endif
   logic [2:0]  red, yellow, green;
   logic [1:0]  active_dir;
   state_t      dut_state;

   // Expected entry: {dir_check, dir[1:0], red[2:0], yellow[2:0], green[2:0]}
   logic [11:0] exp_q[$];
   int total;
   int bad;

   typedef struct {
      logic        valid;
      logic [2:0]  t;
      logic [1:0]  d;
      logic [15:0] data;
      logic [2:0]  r;
      logic [2:0]  y;
      logic [2:0]  g;
   } vec_t;
   vec_t tbl[13];

   traffic_lights_xing #(
      .NUM_DIRS              (3),
      .CLKS_PER_MS           (2),
      .BLINK_HALF_PERIOD_MS  (1),
      .BLINK_GREEN_TIME_TICK (3),
      .RED_YELLOW_MS         (1)
   ) dut (
      .clk_i        (clk),
      .srst_i       (srst),
      .cmd_type_i   (cmd_type),
      .cmd_valid_i  (cmd_valid),
      .cmd_dir_i    (cmd_dir),
      .cmd_data_i   (cmd_data),
`ifdef TL_DEMAND_SKIP_EN
      .demand_i     (demand),
`endif
      .red_o        (red),
      .yellow_o     (yellow),
      .green_o      (green),
      .active_dir_o (active_dir),
      .state_o      (dut_state)
   );

   // Clock
   initial clk = 1'b0;
   always #CLK_HALF clk = ~clk;

   // Watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      srst = 1'b1;
      repeat (2) @(posedge clk);
      #1 srst = 1'b0;
   endtask

   // Drive one command for one cycle; returns 1 time unit after the accepting edge.
   task automatic send(input logic v, input logic [2:0] t, input logic [1:0] d, input logic [15:0] data);
      cmd_valid = v;
      cmd_type  = t;
      cmd_dir   = d;
      cmd_data  = data;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   task automatic push(input logic [2:0] r, input logic [2:0] y, input logic [2:0] g,
                       input logic [1:0] d, input logic dchk, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back({dchk, d, r, y, g});
   endtask

   // One service of direction d: optional RY, green, green-blink (off first), yellow.
   task automatic push_dir(input int d, input int gcyc, input int ycyc, input logic with_ry);
      logic [2:0] m;
      logic [1:0] dd;
      m  = 3'b001 << d;
      dd = 2'(d);
      if (with_ry) push(3'b111, m, 3'b000, dd, 1'b1, 2);
      push(~m, 3'b000, m, dd, 1'b1, gcyc);
      for (int i = 0; i < 6; i++) push(~m, 3'b000, (i % 2 == 1) ? m : 3'b000, dd, 1'b1, 2);
      push(~m, m, 3'b000, dd, 1'b1, ycyc);
   endtask

   task automatic push_clear(input int n, input logic dchk);
      push(3'b111, 3'b000, 3'b000, 2'd0, dchk, n);
   endtask

   // Pop and compare one expected entry per cycle, sampling on the falling edge.
   task automatic check_n(input int n, input string name);
      logic [11:0] e;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s[%0d]: expected queue empty, got r=%b y=%b g=%b", name, i, red, yellow, green);
         end else begin
            e = exp_q.pop_front();
            if ({red, yellow, green} !== e[8:0] || (e[11] && active_dir !== e[10:9])) begin
               bad++;
               $display("FAIL %s[%0d]: got dir=%0d r=%b y=%b g=%b (%s) want dir=%0d r=%b y=%b g=%b",
                        name, i, active_dir, red, yellow, green, dut_state.name(),
                        e[10:9], e[8:6], e[5:3], e[2:0]);
            end
         end
      end
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      srst      = 1'b1;
      cmd_valid = 1'b0;
      cmd_type  = 3'd0;
      cmd_dir   = 2'd0;
      cmd_data  = 16'd0;
`ifdef TL_DEMAND_SKIP_EN
      demand    = 3'b111;
`endif

      // valid, type, dir, data, expected red/yellow/green one cycle after acceptance
      tbl[0]  = '{1'b0, 3'd0, 2'd0, 16'd0, 3'b000, 3'b000, 3'b000}; // ON without valid
      tbl[1]  = '{1'b1, 3'd6, 2'd0, 16'd0, 3'b000, 3'b000, 3'b000}; // undefined type
      tbl[2]  = '{1'b1, 3'd7, 2'd1, 16'd9, 3'b000, 3'b000, 3'b000}; // undefined type
      tbl[3]  = '{1'b1, 3'd3, 2'd0, 16'd1, 3'b000, 3'b000, 3'b000}; // SET in OFF ignored
      tbl[4]  = '{1'b1, 3'd2, 2'd0, 16'd0, 3'b000, 3'b111, 3'b000}; // UNREG, blink on
      tbl[5]  = '{1'b1, 3'd7, 2'd0, 16'd0, 3'b000, 3'b000, 3'b000}; // 2 cycles in: blink off
      tbl[6]  = '{1'b0, 3'd1, 2'd0, 16'd0, 3'b000, 3'b111, 3'b000}; // 4 cycles in: blink on
      tbl[7]  = '{1'b1, 3'd1, 2'd0, 16'd0, 3'b000, 3'b000, 3'b000}; // OFF
      tbl[8]  = '{1'b1, 3'd2, 2'd0, 16'd0, 3'b000, 3'b111, 3'b000}; // UNREG
      tbl[9]  = '{1'b1, 3'd0, 2'd0, 16'd0, 3'b111, 3'b000, 3'b000}; // ON -> CLEAR
      tbl[10] = '{1'b1, 3'd0, 2'd0, 16'd0, 3'b111, 3'b000, 3'b000}; // ON while cycling
      tbl[11] = '{1'b1, 3'd2, 2'd0, 16'd0, 3'b000, 3'b111, 3'b000}; // UNREG from CLEAR
      tbl[12] = '{1'b1, 3'd1, 2'd0, 16'd0, 3'b000, 3'b000, 3'b000}; // OFF

      // Reset state
      do_reset();
      push(3'b000, 3'b000, 3'b000, 2'd0, 1'b1, 1);
      check_n(1, "reset");

      // Single-command vectors
      for (int i = 0; i < 13; i++) begin
         @(posedge clk);
         #1;
         push(tbl[i].r, tbl[i].y, tbl[i].g, 2'd0, 1'b1, 1);
         send(tbl[i].valid, tbl[i].t, tbl[i].d, tbl[i].data);
         check_n(1, $sformatf("vec%0d", i));
      end

      // Full round with default times, SET_* while cycling ignored, wrap 2 -> 0
      do_reset();
      @(posedge clk);
      #1;
      push_clear(4, 1'b1);
      push_dir(0, 20, 4, 1'b1);
      push_clear(4, 1'b0);
      push_dir(1, 20, 4, 1'b1);
      push_clear(4, 1'b0);
      push_dir(2, 20, 4, 1'b1);
      push_clear(4, 1'b0);
      push(3'b111, 3'b001, 3'b000, 2'd0, 1'b1, 2);
      send(1'b1, 3'd0, 2'd0, 16'd0);
      fork
         check_n(exp_q.size(), "round");
         begin
            repeat (30) @(posedge clk);
            #1;
            send(1'b1, 3'd5, 2'd0, 16'd5);
            send(1'b1, 3'd3, 2'd1, 16'd2);
            send(1'b1, 3'd4, 2'd0, 16'd1);
         end
      join

      // Programming in UNREG: green1=3, yellow=0 (->1), clear=3, bad dir and invalid strobe ignored
      @(posedge clk);
      #1;
      send(1'b1, 3'd2, 2'd0, 16'd0);
      send(1'b1, 3'd3, 2'd1, 16'd3);
      send(1'b1, 3'd5, 2'd0, 16'd0);
      send(1'b1, 3'd3, 2'd3, 16'd1);
      send(1'b1, 3'd4, 2'd0, 16'd3);
      send(1'b0, 3'd3, 2'd2, 16'd1);
      send(1'b1, 3'd6, 2'd2, 16'd1);
      push_clear(6, 1'b1);
      push_dir(0, 20, 2, 1'b1);
      push_clear(6, 1'b0);
      push_dir(1, 6, 2, 1'b1);
      push_clear(6, 1'b0);
      push_dir(2, 20, 2, 1'b1);
      push_clear(6, 1'b0);
      push(3'b111, 3'b001, 3'b000, 2'd0, 1'b1, 2);
      send(1'b1, 3'd0, 2'd0, 16'd0);
      check_n(exp_q.size(), "prog");

      // OFF during GREEN, then UNREG blink from its first half-period
      @(posedge clk);
      #1;
      send(1'b1, 3'd1, 2'd0, 16'd0);
      push_clear(6, 1'b1);
      push(3'b111, 3'b001, 3'b000, 2'd0, 1'b1, 2);
      push(3'b110, 3'b000, 3'b001, 2'd0, 1'b1, 5);
      send(1'b1, 3'd0, 2'd0, 16'd0);
      check_n(13, "off_pre");
      @(posedge clk);
      #1;
      push(3'b000, 3'b000, 3'b000, 2'd0, 1'b1, 1);
      send(1'b1, 3'd1, 2'd0, 16'd0);
      check_n(1, "off_now");
      @(posedge clk);
      #1;
      push(3'b000, 3'b111, 3'b000, 2'd0, 1'b1, 2);
      push(3'b000, 3'b000, 3'b000, 2'd0, 1'b1, 2);
      push(3'b000, 3'b111, 3'b000, 2'd0, 1'b1, 2);
      send(1'b1, 3'd2, 2'd0, 16'd0);
      check_n(6, "unreg_blink");

      // Short programmed green, then mid-cycle reset reverts the times
      @(posedge clk);
      #1;
      send(1'b1, 3'd3, 2'd0, 16'd1);
      push_clear(6, 1'b1);
      push(3'b111, 3'b001, 3'b000, 2'd0, 1'b1, 2);
      push(3'b110, 3'b000, 3'b001, 2'd0, 1'b1, 2);
      push(3'b110, 3'b000, 3'b000, 2'd0, 1'b1, 2);
      send(1'b1, 3'd0, 2'd0, 16'd0);
      check_n(12, "short_green");
      @(posedge clk);
      #1 srst = 1'b1;
      @(posedge clk);
      #1 srst = 1'b0;
      push(3'b000, 3'b000, 3'b000, 2'd0, 1'b1, 1);
      check_n(1, "mid_reset");
      @(posedge clk);
      #1;
      push_clear(4, 1'b1);
      push_dir(0, 20, 4, 1'b1);
      push_clear(4, 1'b0);
      push(3'b111, 3'b010, 3'b000, 2'd1, 1'b1, 2);
      send(1'b1, 3'd0, 2'd0, 16'd0);
      check_n(exp_q.size(), "revert");

`ifdef TL_DEMAND_SKIP_EN
      // Only dir2 has demand: dirs 0 and 1 skipped, dir2 served repeatedly
      begin
         logic seen;
         do_reset();
         demand = 3'b100;
         @(posedge clk);
         #1;
         push_clear(4, 1'b1);
         push_dir(2, 20, 4, 1'b1);
         push_clear(4, 1'b0);
         push(3'b111, 3'b100, 3'b000, 2'd2, 1'b1, 2);
         send(1'b1, 3'd0, 2'd0, 16'd0);
         check_n(exp_q.size(), "demand_skip");
         // No demand: all red held indefinitely after clearance
         demand = 3'b000;
         push_dir(2, 20, 4, 1'b0);
         push_clear(24, 1'b0);
         check_n(exp_q.size(), "demand_none");
         // Demand appears on dir0: served at the next ms boundary
         demand = 3'b001;
         seen = 1'b0;
         for (int i = 0; i < 6 && !seen; i++) begin
            @(negedge clk);
            if (red == 3'b111 && yellow == 3'b001 && active_dir == 2'd0) seen = 1'b1;
         end
         total++;
         if (!seen) begin
            bad++;
            $display("FAIL demand_resume: got dir=%0d r=%b y=%b want dir=0 r=111 y=001 within 6 cycles",
                     active_dir, red, yellow);
         end
      end
`endif

      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL leftover: got %0d unchecked entries want 0", exp_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
